// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op-code values, FSM state encoding and datapath kind shared by
// the HI/LO multiply/divide sequencer, its iteration datapath and its bench.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_MULT  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Which recurrence the iteration datapath runs
    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } kind_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage side of the HI/LO unit. The pipeline drives the
// master modport; muldiv_ctrl sits on the slave modport.
interface muldiv_if #(parameter int WIDTH = 32);

    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, rs_val, rt_val, flush,
        input  stall, busy, rd_data, rd_valid, hi, lo
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, flush,
        output stall, busy, rd_data, rd_valid, hi, lo
    );

endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: unsigned shift-add multiplier / restoring divider, one bit per
// cycle for WIDTH cycles. Operands arrive as magnitudes; sign handling lives in
// muldiv_ctrl. done and the result are combinational in the final iteration so
// the caller can commit on the same edge the last step completes.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  kind_t            kind,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             done
);

    localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic             running;
    logic [CW-1:0]    cnt;
    kind_t            kind_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // One recurrence step: acc_hi is the partial product / partial remainder,
    // acc_lo holds the multiplier bits still to consume or the quotient so far.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        nxt_hi    = acc_hi;
        nxt_lo    = acc_lo;
        if (kind_q == KIND_MUL) begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            nxt_hi = div_diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Final-step outputs; the caller only looks at them while done is high.
    always_comb begin
        result_hi = nxt_hi;
        result_lo = nxt_lo;
        done      = running && (cnt == LAST);
    end

    // Operand load, per-cycle iteration and the WIDTH-cycle up-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            kind_q  <= KIND_MUL;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb_q   <= '0;
        end else if (abort) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            kind_q  <= kind;
            acc_hi  <= '0;
            acc_lo  <= opa;
            opb_q   <= opb;
        end else if (running) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            if (cnt == LAST) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO sequencer beside the execute stage. Accepts one HI/LO
// op per cycle while idle, runs MULTU/DIV/DIVU (and MULT) through muldiv_iter,
// stalls the pipeline while the unit is busy and drops work on flush.
// Build option MULDIV_MULT_EN: op 7 becomes signed MULT; otherwise op 7 is an
// accepted no-op.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ready; MTxx/MFxx complete here, arithmetic ops launch RUN
//   ST_RUN  | iterating; every op_valid stalls; commit or flush returns IDLE
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

`ifdef MULDIV_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    state_t state;
    state_t state_nxt;

    logic               accept;
    logic               start;
    logic               abort;
    logic               commit;
    logic               stall_o;
    logic               busy_o;
    logic               rd_valid_o;
    logic [WIDTH-1:0]   rd_data_o;

    logic               is_mul;
    logic               is_div;
    logic               is_signed;
    logic               neg_a;
    logic               neg_b;
    kind_t              kind_d;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    kind_t              kind_q;
    logic               neg_q;
    logic               neg_r;
    logic               div0_q;
    logic [WIDTH-1:0]   rs_q;

    logic [WIDTH-1:0]   iter_hi;
    logic [WIDTH-1:0]   iter_lo;
    logic               iter_done;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   commit_hi;
    logic [WIDTH-1:0]   commit_lo;

    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Op decode and sign pre-processing: the datapath only sees magnitudes.
    always_comb begin
        is_mul    = (bus.op == OP_MULTU) || (MULT_EN && (bus.op == OP_MULT));
        is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        is_signed = (bus.op == OP_DIV) || (MULT_EN && (bus.op == OP_MULT));
        neg_a     = is_signed && bus.rs_val[WIDTH-1];
        neg_b     = is_signed && bus.rt_val[WIDTH-1];
        mag_a     = neg_a ? -bus.rs_val : bus.rs_val;
        mag_b     = neg_b ? -bus.rt_val : bus.rt_val;
        kind_d    = is_div ? KIND_DIV : KIND_MUL;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush wins over a same-cycle completion.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (bus.flush || iter_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: accept/stall split, launch, abort, commit and the MFxx read.
    always_comb begin
        accept     = bus.op_valid && !bus.flush && (state == ST_IDLE);
        stall_o    = bus.op_valid && !bus.flush && (state == ST_RUN);
        busy_o     = (state == ST_RUN);
        start      = accept && (is_mul || is_div);
        abort      = (state == ST_RUN) && bus.flush;
        commit     = (state == ST_RUN) && !bus.flush && iter_done;
        rd_valid_o = accept && ((bus.op == OP_MFHI) || (bus.op == OP_MFLO));
        rd_data_o  = '0;
        if (rd_valid_o) begin
            rd_data_o = (bus.op == OP_MFHI) ? hi_q : lo_q;
        end
    end

    // Capture what post-processing needs; the datapath keeps its own operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q <= KIND_MUL;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0_q <= 1'b0;
            rs_q   <= '0;
        end else if (start) begin
            kind_q <= kind_d;
            neg_q  <= neg_a ^ neg_b;
            neg_r  <= neg_a;
            div0_q <= is_div && (bus.rt_val == '0);
            rs_q   <= bus.rs_val;
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .kind      (kind_d),
        .opa       (mag_a),
        .opb       (mag_b),
        .result_hi (iter_hi),
        .result_lo (iter_lo),
        .done      (iter_done)
    );

    // Sign post-processing. Divide by zero reports all-ones / dividend as-is;
    // most-negative / -1 falls out naturally as 0x8000_0000 remainder 0.
    always_comb begin
        prod      = {iter_hi, iter_lo};
        prod_s    = neg_q ? -prod : prod;
        commit_hi = prod_s[2*WIDTH-1:WIDTH];
        commit_lo = prod_s[WIDTH-1:0];
        if (kind_q == KIND_DIV) begin
            if (div0_q) begin
                commit_hi = rs_q;
                commit_lo = '1;
            end else begin
                commit_hi = neg_r ? -iter_hi : iter_hi;
                commit_lo = neg_q ? -iter_lo : iter_lo;
            end
        end
    end

    // HI/LO registers: arithmetic commit or MTHI/MTLO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= commit_hi;
            lo_q <= commit_lo;
        end else if (accept) begin
            if (bus.op == OP_MTHI) hi_q <= bus.rs_val;
            if (bus.op == OP_MTLO) lo_q <= bus.rs_val;
        end
    end

    assign bus.stall    = stall_o;
    assign bus.busy     = busy_o;
    assign bus.rd_valid = rd_valid_o;
    assign bus.rd_data  = rd_data_o;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
